// File: rtl/fifo_uart_tx_if.sv
// Signal bundle between the UART transmit stage and its upstream FIFO read port.
// The slave modport is the transmitter's view; master is the FIFO/controller side.
interface fifo_uart_tx_if;
  logic       enable_i;
  logic       fifo_empty_i;
  logic [7:0] fifo_data_i;
  logic       fifo_rd_en_o;
  logic       tx_o;
  logic       busy_o;
  logic       frame_done_o;

  modport slave (
    input  enable_i, fifo_empty_i, fifo_data_i,
    output fifo_rd_en_o, tx_o, busy_o, frame_done_o
  );

  modport master (
    output enable_i, fifo_empty_i, fifo_data_i,
    input  fifo_rd_en_o, tx_o, busy_o, frame_done_o
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// UART 8N1 transmitter that pops one byte per frame from a synchronous FIFO.
// All outputs are decoded from registered state (Moore), so no input reaches an output combinationally.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  fifo_uart_tx_if.slave  bus
);

  localparam int DATA_W = 8;
  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    STOP
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          idx_q, idx_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic                cnt_done;
  logic                can_start;

  assign cnt_done  = (cnt_q == CNT_MAX);
  assign can_start = bus.enable_i && !bus.fifo_empty_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    unique case (state_q)
      IDLE: begin
        if (can_start) state_d = FETCH;
      end
      FETCH: begin
        state_d = LOAD;
      end
      // FIFO read data is registered, so it is only valid one cycle after the pop.
      LOAD: begin
        shreg_d = bus.fifo_data_i;
        cnt_d   = '0;
        idx_d   = '0;
        state_d = START;
      end
      START: begin
        if (cnt_done) begin
          cnt_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_done) begin
          cnt_d   = '0;
          shreg_d = {1'b0, shreg_q[DATA_W-1:1]};
          if (idx_q == 3'd7) state_d = STOP;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      // Enable and empty are only consulted here, so mid-frame changes are ignored.
      STOP: begin
        if (cnt_done) begin
          cnt_d   = '0;
          state_d = can_start ? FETCH : IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    bus.tx_o = 1'b1;
    if (state_q == START)     bus.tx_o = 1'b0;
    else if (state_q == DATA) bus.tx_o = shreg_q[0];
  end

  assign bus.fifo_rd_en_o = (state_q == FETCH);
  assign bus.busy_o       = (state_q != IDLE);
  assign bus.frame_done_o = (state_q == STOP) && cnt_done;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx at CLKS_PER_BIT=4 with a small behavioural FIFO
// (registered read data, count-based empty flag) feeding the read port.
module tb_fifo_uart_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic       tb_empty = 1'b1;
  logic [7:0] tb_rdata = 8'h00;
  logic       push_en = 1'b0;
  logic [7:0] push_data = 8'h00;
  logic [7:0] q[$];

  int n_chk = 0;
  int n_fail = 0;
  int rd_cnt = 0;
  int rd_empty_cnt = 0;
  int done_cnt = 0;

  fifo_uart_tx_if u_if ();

  assign u_if.enable_i     = en;
  assign u_if.fifo_empty_i = tb_empty;
  assign u_if.fifo_data_i  = tb_rdata;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  always #5 clk = ~clk;

  // Behavioural FIFO plus pulse counters; all sampled on the pre-edge values.
  always @(posedge clk) begin
    if (u_if.frame_done_o) done_cnt++;
    if (u_if.fifo_rd_en_o) begin
      rd_cnt++;
      if (tb_empty) rd_empty_cnt++;
      if (q.size() > 0) tb_rdata <= q.pop_front();
    end
    if (push_en) q.push_back(push_data);
    tb_empty <= (q.size() == 0);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("%s FAIL: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    @(negedge clk);
    push_en   = 1'b1;
    push_data = b;
    @(negedge clk);
    push_en   = 1'b0;
  endtask

  task automatic wait_start(output int w);
    w = 999;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (u_if.tx_o === 1'b0) begin
        w = i;
        break;
      end
    end
  endtask

  // Waits for the start bit (expected exactly 3 negedges after the caller's negedge)
  // and captures the 40 frame cycles of tx, frame_done and busy.
  task automatic expect_frame(input string tag, input logic [7:0] b);
    int          w;
    logic [9:0]  bits;
    logic [39:0] exp_tx, obs_tx, obs_fd, obs_busy;
    bits = {1'b1, b, 1'b0};
    for (int c = 0; c < 10 * CPB; c++) exp_tx[c] = bits[c / CPB];
    wait_start(w);
    check({tag, "_gap"}, 64'(w), 64'd3);
    for (int c = 0; c < 10 * CPB; c++) begin
      if (c != 0) @(negedge clk);
      obs_tx[c]   = u_if.tx_o;
      obs_fd[c]   = u_if.frame_done_o;
      obs_busy[c] = u_if.busy_o;
    end
    check({tag, "_tx"}, 64'(obs_tx), 64'(exp_tx));
    check({tag, "_done"}, 64'(obs_fd), 64'h80_0000_0000);
    check({tag, "_busy"}, 64'(obs_busy), 64'hFF_FFFF_FFFF);
  endtask

  int          r0, d0, low, w;
  logic [7:0]  fill_tbl [8] = '{8'h01, 8'h80, 8'hC3, 8'h7E, 8'h99, 8'h00, 8'hFF, 8'h5A};

  initial begin
    #2 rst_n = 1'b0;
    #1;
    check("rst_tx", 64'(u_if.tx_o), 64'd1);
    check("rst_busy", 64'(u_if.busy_o), 64'd0);
    check("rst_rd", 64'(u_if.fifo_rd_en_o), 64'd0);
    check("rst_done", 64'(u_if.frame_done_o), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_tx", 64'(u_if.tx_o), 64'd1);
    check("idle_busy", 64'(u_if.busy_o), 64'd0);
    check("idle_rdcnt", 64'(rd_cnt), 64'd0);

    // Single byte with enable already high.
    en = 1'b1;
    push(8'hA5);
    expect_frame("a5", 8'hA5);
    @(negedge clk);
    check("a5_busy_end", 64'(u_if.busy_o), 64'd0);
    check("a5_rdcnt", 64'(rd_cnt), 64'd1);
    check("a5_donecnt", 64'(done_cnt), 64'd1);

    // Enable gating: nothing moves while enable is low; dropping it mid-frame stops the next fetch.
    en = 1'b0;
    push(8'h55);
    push(8'h12);
    r0  = rd_cnt;
    low = 0;
    repeat (20) begin
      @(negedge clk);
      if (u_if.tx_o !== 1'b1) low++;
    end
    check("gate_low", 64'(low), 64'd0);
    check("gate_rd", 64'(rd_cnt - r0), 64'd0);
    en = 1'b1;
    fork
      expect_frame("g55", 8'h55);
      begin
        repeat (20) @(negedge clk);
        en = 1'b0;
      end
    join
    low = 0;
    repeat (20) begin
      @(negedge clk);
      if (u_if.tx_o !== 1'b1) low++;
    end
    check("gate_after_low", 64'(low), 64'd0);
    check("gate_after_busy", 64'(u_if.busy_o), 64'd0);
    check("gate_after_rd", 64'(rd_cnt - r0), 64'd1);
    check("gate_fifo_left", 64'(q.size()), 64'd1);

    // Mid-frame reset during data bit 3 of 0x12 (bit 3 is 0, so tx must jump high).
    push(8'h69);
    en = 1'b1;
    wait_start(w);
    check("mrst_gap", 64'(w), 64'd3);
    repeat (17) @(negedge clk);
    check("mrst_pre_tx", 64'(u_if.tx_o), 64'd0);
    rst_n = 1'b0;
    #1;
    check("mrst_tx", 64'(u_if.tx_o), 64'd1);
    check("mrst_busy", 64'(u_if.busy_o), 64'd0);
    check("mrst_rd", 64'(u_if.fifo_rd_en_o), 64'd0);
    check("mrst_done", 64'(u_if.frame_done_o), 64'd0);
    repeat (2) @(negedge clk);
    check("mrst_hold_tx", 64'(u_if.tx_o), 64'd1);
    rst_n = 1'b1;
    expect_frame("mrst_next", 8'h69);
    @(negedge clk);
    check("mrst_busy_end", 64'(u_if.busy_o), 64'd0);

    // Back-to-back frames with exactly two idle-high cycles between them.
    en = 1'b0;
    push(8'h00);
    push(8'hFF);
    push(8'h3C);
    r0 = rd_cnt;
    d0 = done_cnt;
    en = 1'b1;
    expect_frame("b2b_00", 8'h00);
    expect_frame("b2b_ff", 8'hFF);
    expect_frame("b2b_3c", 8'h3C);
    @(negedge clk);
    check("b2b_busy_end", 64'(u_if.busy_o), 64'd0);
    check("b2b_rd", 64'(rd_cnt - r0), 64'd3);
    check("b2b_done", 64'(done_cnt - d0), 64'd3);
    check("b2b_empty", 64'(tb_empty), 64'd1);

    // Full FIFO drained to empty.
    en = 1'b0;
    foreach (fill_tbl[i]) push(fill_tbl[i]);
    check("fill_size", 64'(q.size()), 64'd8);
    r0 = rd_cnt;
    en = 1'b1;
    foreach (fill_tbl[i]) expect_frame($sformatf("fill%0d", i), fill_tbl[i]);
    @(negedge clk);
    check("fill_busy_end", 64'(u_if.busy_o), 64'd0);
    check("fill_rd", 64'(rd_cnt - r0), 64'd8);
    repeat (20) @(negedge clk);
    check("fill_rd_hold", 64'(rd_cnt - r0), 64'd8);
    check("fill_tx_idle", 64'(u_if.tx_o), 64'd1);
    check("rd_while_empty", 64'(rd_empty_cnt), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
